// File: rtl/pmem_burst_responder_if.sv
// Line-side and beat-side signals of the pmem burst responder, bundled as one interface.
// The responder uses the slave view; the initiator/memory environment uses the master view.
interface pmem_burst_responder_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
);
    logic [31:0]           pmem_address;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic [31:0]           mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [BEAT_WIDTH-1:0] mem_wdata;
    logic [BEAT_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_resp,
        output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_resp,
        input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/pmem_burst_responder.sv
// Turns one whole-line read/write request into a fixed 4-beat burst on the narrow memory
// port, assembling read beats into a line and pulsing pmem_resp once the burst completes.
module pmem_burst_responder #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    pmem_burst_responder_if.slave bus
);
    localparam int NBEATS   = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W    = $clog2(NBEATS);
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, RBURST, WBURST, RESP} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [31:0]           addr_q;
    logic [LINE_WIDTH-1:0] rline_q;
    logic [LINE_WIDTH-1:0] wline_q;
    logic [BEAT_WIDTH-1:0] wbeat_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  resp_q;

    logic                  last_beat;
    logic                  accept_wr;
    logic [31:0]           line_base;
    logic                  unused_offset_bits;

    assign cnt_d     = cnt_q + 1'b1;
    assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
    assign accept_wr = (state_q == IDLE) && !bus.pmem_read && bus.pmem_write;
    assign line_base = {bus.pmem_address[31:OFFSET_W], OFFSET_W'(0)};
    assign unused_offset_bits = ^bus.pmem_address[OFFSET_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rline_q     <= '0;
            wbeat_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            resp_q      <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Read has priority: a simultaneous write is neither latched nor performed.
                    if (bus.pmem_read) begin
                        addr_q     <= line_base;
                        mem_read_q <= 1'b1;
                        state_q    <= RBURST;
                    end else if (bus.pmem_write) begin
                        addr_q      <= line_base;
                        wbeat_q     <= bus.pmem_wdata[BEAT_WIDTH-1:0];
                        mem_write_q <= 1'b1;
                        state_q     <= WBURST;
                    end
                end
                RBURST: begin
                    if (bus.mem_resp) begin
                        rline_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rdata;
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            mem_read_q <= 1'b0;
                            resp_q     <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                WBURST: begin
                    if (bus.mem_resp) begin
                        // Present the next beat from the latched line, not the live input.
                        wbeat_q <= wline_q[cnt_d*BEAT_WIDTH +: BEAT_WIDTH];
                        cnt_q   <= cnt_d;
                        if (last_beat) begin
                            mem_write_q <= 1'b0;
                            resp_q      <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: pure data holding register; it is always rewritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            wline_q <= bus.pmem_wdata;
        end
    end

    assign bus.pmem_rdata  = rline_q;
    assign bus.pmem_resp   = resp_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_wdata   = wbeat_q;
endmodule
